// File: rtl/shift_right_seq_if.sv
// Start/busy/done handshake and operand/result bus between the ALU control FSM
// (master) and the multi-cycle right shifter (slave).
interface shift_right_seq_if #(
    parameter int N   = 8,
    parameter int SHW = 3
);
    logic           start;
    logic           arith;
    logic           rot;
    logic [N-1:0]   dataa;
    logic [SHW-1:0] shamt;
    logic           busy;
    logic           done;
    logic [N-1:0]   dataout;

    modport master (
        output start, arith, rot, dataa, shamt,
        input  busy, done, dataout
    );

    modport slave (
        input  start, arith, rot, dataa, shamt,
        output busy, done, dataout
    );
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit position per clock, logical or arithmetic fill.
// Define SHIFT_ROTATE_EN to add rotate-right fill selected by the latched rot bit.
module shift_right_seq #(
    parameter int N   = 8,
    parameter int SHW = 3
) (
    input logic              clk,
    input logic              rst_n,
    shift_right_seq_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; dataout holds the last result
    // SHIFT | shifting one position per clock; busy high
    // DONE  | one-cycle completion pulse; a new start is accepted here
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   data_q, data_d;
    logic           arith_q, arith_d;
    logic           fill;

`ifdef SHIFT_ROTATE_EN
    logic rot_q, rot_d;

    assign fill = rot_q ? data_q[0] : (arith_q & data_q[N-1]);
`else
    logic rot_unused;

    assign rot_unused = bus.rot;
    assign fill       = arith_q & data_q[N-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        arith_d = arith_q;
`ifdef SHIFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    data_d  = bus.dataa;
                    cnt_d   = bus.shamt;
                    arith_d = bus.arith;
`ifdef SHIFT_ROTATE_EN
                    rot_d   = bus.rot;
`endif
                    state_d = (bus.shamt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                data_d = {fill, data_q[N-1:1]};
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            arith_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            arith_q <= arith_d;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Status flags decode the state register directly, so they cannot glitch.
    assign bus.busy    = (state_q == S_SHIFT);
    assign bus.done    = (state_q == S_DONE);
    assign bus.dataout = data_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: directed operations push expected results,
// a negedge monitor pops and checks result, busy length and latency on each done.
module tb_shift_right_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   busy_cnt;

    typedef struct {
        logic [7:0] data;
        int         sh;
        int         cyc;
    } exp_t;

    exp_t sbq[$];

    shift_right_seq_if #(.N(8), .SHW(3)) bus ();

    shift_right_seq #(.N(8), .SHW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%0h required=no_done", bus.dataout);
                end else begin
                    e = sbq.pop_front();
                    check("result", {24'h0, bus.dataout}, {24'h0, e.data});
                    check("busy_cycles", busy_cnt, e.sh);
                    check("latency", cyc - e.cyc, e.sh + 1);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drives start at the current negedge; returns at the negedge where done is expected.
    task automatic issue(input logic [7:0] a, input int sh, input logic ar, input logic ro,
                         input logic [7:0] exp);
        exp_t e;
        bus.start = 1'b1;
        bus.dataa = a;
        bus.shamt = 3'(sh);
        bus.arith = ar;
        bus.rot   = ro;
        e.data = exp;
        e.sh   = sh;
        e.cyc  = cyc;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (sh) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [7:0] rot_exp;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        busy_cnt = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.arith = 1'b0;
        bus.rot   = 1'b0;
        bus.dataa = 8'h00;
        bus.shamt = 3'd0;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_done", {31'h0, bus.done}, 32'h0);
        check("reset_dataout", {24'h0, bus.dataout}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'hF0, 3, 1'b0, 1'b0, 8'h1E);
        @(negedge clk);
        issue(8'hF0, 3, 1'b1, 1'b0, 8'hFE);
        @(negedge clk);
        issue(8'h70, 7, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        issue(8'h96, 7, 1'b1, 1'b0, 8'hFF);
        @(negedge clk);
        // Zero shift followed by a start during its done cycle.
        issue(8'hA5, 0, 1'b0, 1'b0, 8'hA5);
        issue(8'h80, 1, 1'b0, 1'b0, 8'h40);
        @(negedge clk);

        // A start while busy must be ignored.
        bus.start = 1'b1;
        bus.dataa = 8'hFF;
        bus.shamt = 3'd7;
        bus.arith = 1'b0;
        bus.rot   = 1'b0;
        e.data = 8'h01;
        e.sh   = 7;
        e.cyc  = cyc;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataa = 8'h00;
        bus.shamt = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        @(negedge clk);

        // Reset mid-shift: partial result discarded, no done.
        bus.start = 1'b1;
        bus.dataa = 8'hFF;
        bus.shamt = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, bus.busy}, 32'h0);
        check("midrst_done", {31'h0, bus.done}, 32'h0);
        check("midrst_dataout", {24'h0, bus.dataout}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

`ifdef SHIFT_ROTATE_EN
        rot_exp = 8'hC0;
`else
        rot_exp = 8'h40;
`endif
        issue(8'h81, 1, 1'b0, 1'b1, rot_exp);
        @(negedge clk);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multi-cycle right-shift unit for the ALU datapath, complementing the existing single-cycle left shifter. Accepts an operand and shift amount on a start strobe, shifts one bit position per clock (logical or arithmetic), then pulses `done` with the result held on `dataout`. It sits beside the ALU operand registers and is sequenced by the ALU control FSM via a start/busy/done handshake.

## Interface
- `N`, 8: operand/result width in bits.
- `SHW`, 3: width of `shamt`; legal shift amounts are 0 to 2^SHW−1.
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` input 1: request strobe, sampled on rising `clk`.
- `arith` input 1: 1 = arithmetic shift (sign fill), 0 = logical shift (zero fill); captured with `start`.
- `rot` input 1: rotate request; captured with `start`; effective only with `SHIFT_ROTATE_EN`.
- `dataa` input N: operand, captured with `start`.
- `shamt` input SHW: shift amount, captured with `start`.
- `busy` output 1: high while shifting.
- `done` output 1: one-cycle completion pulse.
- `dataout` output N: result register.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1: load `dataout`←`dataa`, `cnt`←`shamt`, latch `arith`/`rot`.
  - If `shamt`≠0, go to SHIFT.
  - If `shamt`=0, go to DONE.
- IDLE or DONE with `start`=0: DONE goes to IDLE. IDLE stays in IDLE.
- SHIFT, each cycle:
  - `dataout`←{fill, `dataout`[N−1:1]}; `cnt`←`cnt`−1.
  - Fill bit is `dataout`[N−1] if `arith`, else 0; rotate overrides (see Configuration).
  - Go to DONE when `cnt`=1.
- `start` is ignored in SHIFT; inputs are not re-sampled.
- Arithmetic shift by N−1 or more yields all sign bits. Logical shift by N or more yields 0.
- `dataout` holds its value in IDLE and DONE until the next accepted `start`.
- `busy` = (state==SHIFT). `done` = (state==DONE). Both are registered state decodes, glitch-free.
- Reset asserted mid-operation: immediate return to IDLE. The partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `dataout`=0, `cnt`=0, state IDLE.
- Start sampled at edge E0:
  - `busy` is high from E0 to E0+`shamt`.
  - `done` is high for the single cycle after edge E0+`shamt`.
  - Latency is `shamt`+1 cycles.
- `shamt`=0: `done` rises right after E0 with `dataout`=`dataa`. `busy` stays 0.
- Back-to-back: `start` during the `done` cycle is accepted. There is no IDLE bubble, giving throughput of one op per `shamt`+1 cycles.
- `dataout` is valid and stable whenever `done`=1 and stays stable until the next accepted `start`.
- `rst_n` deassertion takes effect at the next rising `clk`. Integration provides reset synchronization.

## Configuration
- `SHIFT_ROTATE_EN` defined:
  - If the latched `rot`=1, the fill bit is `dataout`[0] (rotate right), and `arith` is ignored.
  - If `rot`=0, behaviour is as in Operation.
- `SHIFT_ROTATE_EN` undefined: `rot` is present but ignored (treated as 0). No rotate logic is synthesized.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles. Expect `busy`=0, `done`=0, `dataout`=8'h00.
- Logical shift: `dataa`=8'hF0, `shamt`=3, `arith`=0, `start` pulse. Expect `busy`=1 for 3 cycles, then `done`=1 for 1 cycle with `dataout`=8'h1E.
- Arithmetic shift:
  - `dataa`=8'hF0, `shamt`=3, `arith`=1: expect 8'hFE.
  - `dataa`=8'h70, `shamt`=7, `arith`=1: expect 8'h00.
- Zero shift and back-to-back:
  - `dataa`=8'hA5, `shamt`=0: expect `done` the next cycle with 8'hA5 and no `busy`.
  - Then `start` during `done` with `dataa`=8'h80, `shamt`=1, `arith`=0: expect 8'h40.
- Busy ignore and reset mid-shift:
  - `start` with `dataa`=8'hFF, `shamt`=7; a second `start` with `dataa`=8'h00 at cycle 2 is ignored, and the result is 8'h01.
  - Repeat the first op and pull `rst_n` low at cycle 3: expect outputs return to 0 immediately, and no `done`.
- Rotate: `dataa`=8'h81, `shamt`=1, `rot`=1. Expect 8'hC0 with `SHIFT_ROTATE_EN`, 8'h40 without.
